// File: rtl/ram_bus_arbiter.sv
// Two-port round-robin arbiter that sequences CPU and loader accesses to the shared 256x16 RAM bus.
// Each access is IDLE -> ACCESS -> ACK, and every output comes straight from a flop.
module ram_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuAck,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              LdReq,
    input  logic              LdWe,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdWData,
    output logic              LdAck,
    output logic [DATA_W-1:0] LdRData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic              RamIn,
    output logic              RamOut,
    output logic              BusDrv,
    output logic [DATA_W-1:0] BusWData,
    input  logic [DATA_W-1:0] Bus,
    output logic              Busy,
    output logic              Owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                ram_in_q, ram_in_d;
    logic                ram_out_q, ram_out_d;
    logic                bus_drv_q, bus_drv_d;
    logic                busy_q, busy_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ld_ack_q, ld_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
    logic                grant_ld_s;

    // Next-state and next-output logic; strobes are computed one cycle early so they are registered.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        ram_addr_d   = ram_addr_q;
        bus_wdata_d  = bus_wdata_q;
        ram_in_d     = 1'b0;
        ram_out_d    = 1'b0;
        bus_drv_d    = 1'b0;
        busy_d       = 1'b0;
        cpu_ack_d    = 1'b0;
        ld_ack_d     = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        grant_ld_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CpuReq || LdReq) begin
                    // On a tie the port that did not win last time is granted.
                    grant_ld_s   = (CpuReq && LdReq) ? ~last_owner_q : LdReq;
                    owner_d      = grant_ld_s;
                    last_owner_d = grant_ld_s;
                    we_d         = grant_ld_s ? LdWe : CpuWe;
                    ram_addr_d   = grant_ld_s ? LdAddr : CpuAddr;
                    bus_wdata_d  = grant_ld_s ? LdWData : CpuWData;
                    ram_in_d     = we_d;
                    ram_out_d    = ~we_d;
                    bus_drv_d    = we_d;
                    busy_d       = 1'b1;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy_d    = 1'b1;
                cpu_ack_d = ~owner_q;
                ld_ack_d  = owner_q;
                state_d   = ST_ACK;
                if (!we_q) begin
                    if (owner_q) begin
                        ld_rdata_d = Bus;
                    end else begin
                        cpu_rdata_d = Bus;
                    end
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            bus_wdata_q  <= {DATA_W{1'b0}};
            ram_in_q     <= 1'b0;
            ram_out_q    <= 1'b0;
            bus_drv_q    <= 1'b0;
            busy_q       <= 1'b0;
            cpu_ack_q    <= 1'b0;
            ld_ack_q     <= 1'b0;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            ld_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            ram_addr_q   <= ram_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            ram_in_q     <= ram_in_d;
            ram_out_q    <= ram_out_d;
            bus_drv_q    <= bus_drv_d;
            busy_q       <= busy_d;
            cpu_ack_q    <= cpu_ack_d;
            ld_ack_q     <= ld_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    assign CpuAck   = cpu_ack_q;
    assign CpuRData = cpu_rdata_q;
    assign LdAck    = ld_ack_q;
    assign LdRData  = ld_rdata_q;
    assign RamAddr  = ram_addr_q;
    assign RamIn    = ram_in_q;
    assign RamOut   = ram_out_q;
    assign BusDrv   = bus_drv_q;
    assign BusWData = bus_wdata_q;
    assign Busy     = busy_q;
    assign Owner    = owner_q;

endmodule
